// File: rtl/tf_adder.sv
// Element-wise single-precision adder for two WIDTH x WIDTH matrices.
// One shared four-step FSM sequences N parallel lanes: align, add, normalize/round.
module tf_adder #(
    parameter int WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic [WIDTH*WIDTH*32-1:0]    A,
    input  logic [WIDTH*WIDTH*32-1:0]    B,
    output logic [WIDTH*WIDTH*32-1:0]    result,
    output logic                         ready
);
    localparam int N = WIDTH * WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

    state_t          r_state, w_state_next;
    logic            w_capture, w_align_en, w_add_en, w_norm_en;
    logic            r_ready;
    logic [N*32-1:0] r_a, r_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (load) w_state_next = S_ALIGN;
            S_ALIGN: w_state_next = S_ADD;
            S_ADD:   w_state_next = S_NORM;
            S_NORM:  w_state_next = S_DONE;
            S_DONE:  if (!load) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_capture  = (r_state == S_IDLE) && load;
        w_align_en = (r_state == S_ALIGN);
        w_add_en   = (r_state == S_ADD);
        w_norm_en  = (r_state == S_NORM);
    end

    // ready survives the return to IDLE and only drops when a new load is taken
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ready <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
        end else if (w_capture) begin
            r_ready <= 1'b0;
            r_a     <= A;
            r_b     <= B;
        end else if (w_norm_en) begin
            r_ready <= 1'b1;
        end
    end

    assign ready = r_ready;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [31:0] w_a, w_b;
            logic        w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan;
            logic [30:0] w_mag_a, w_mag_b;
            logic        w_swap, w_sl;
            logic [7:0]  w_el, w_es, w_diff;
            logic [23:0] w_ml, w_ms;
            logic [49:0] w_shift;
            logic [26:0] w_ms_al;
            logic        w_spec;
            logic [31:0] w_spec_val;

            logic        r_spec, r_sign, r_sub;
            logic [31:0] r_spec_val;
            logic [7:0]  r_exp;
            logic [26:0] r_ml, r_ms;
            logic [27:0] r_sum;
            logic [31:0] r_res;

            logic [4:0]  w_lz;
            logic [27:0] w_n;
            logic        w_round_up;
            logic [24:0] w_mant;
            logic [9:0]  w_exp_n;
            logic [22:0] w_frac;
            logic [31:0] w_res;

            assign w_a = r_a[32*gi +: 32];
            assign w_b = r_b[32*gi +: 32];

            // Subnormals are treated as signed zero from here on
            always_comb begin
                w_zero_a = (w_a[30:23] == 8'd0);
                w_zero_b = (w_b[30:23] == 8'd0);
                w_inf_a  = (w_a[30:23] == 8'hFF) && (w_a[22:0] == 23'd0);
                w_inf_b  = (w_b[30:23] == 8'hFF) && (w_b[22:0] == 23'd0);
                w_nan    = ((w_a[30:23] == 8'hFF) && (w_a[22:0] != 23'd0)) ||
                           ((w_b[30:23] == 8'hFF) && (w_b[22:0] != 23'd0)) ||
                           (w_inf_a && w_inf_b && (w_a[31] != w_b[31]));
                w_mag_a  = w_zero_a ? 31'd0 : w_a[30:0];
                w_mag_b  = w_zero_b ? 31'd0 : w_b[30:0];
                w_swap   = (w_mag_b > w_mag_a);
                w_sl     = w_swap ? w_b[31] : w_a[31];
                w_el     = w_swap ? w_mag_b[30:23] : w_mag_a[30:23];
                w_es     = w_swap ? w_mag_a[30:23] : w_mag_b[30:23];
                w_ml     = w_swap ? {!w_zero_b, w_mag_b[22:0]} : {!w_zero_a, w_mag_a[22:0]};
                w_ms     = w_swap ? {!w_zero_a, w_mag_a[22:0]} : {!w_zero_b, w_mag_b[22:0]};
                w_diff   = w_el - w_es;
                w_shift  = {w_ms, 26'd0} >> w_diff;
                if (w_diff >= 8'd26) w_ms_al = {26'd0, |w_ms};
                else                 w_ms_al = {w_shift[49:24], w_shift[23] | (|w_shift[22:0])};

                w_spec     = 1'b1;
                w_spec_val = 32'h7FC0_0000;
                if (w_nan)                      w_spec_val = 32'h7FC0_0000;
                else if (w_inf_a)               w_spec_val = {w_a[31], 8'hFF, 23'd0};
                else if (w_inf_b)               w_spec_val = {w_b[31], 8'hFF, 23'd0};
                else if (w_zero_a && w_zero_b)  w_spec_val = {w_a[31] & w_b[31], 31'd0};
                else                            w_spec     = 1'b0;
            end

            // The normalized value keeps its leading one at bit 27: 24-bit
            // significand above guard (3), round (2) and sticky (1:0).
            always_comb begin
                w_lz = 5'd0;
                for (int i = 0; i < 28; i++)
                    if (r_sum[i]) w_lz = 5'(27 - i);
                w_n        = r_sum << w_lz;
                w_round_up = w_n[3] & (w_n[4] | w_n[2] | w_n[1] | w_n[0]);
                w_mant     = {1'b0, w_n[27:4]} + 25'(w_round_up);
                w_frac     = w_mant[24] ? w_mant[23:1] : w_mant[22:0];
                w_exp_n    = {2'b00, r_exp} + 10'd1 - {5'd0, w_lz} + 10'(w_mant[24]);
                if (r_spec)                             w_res = r_spec_val;
                else if (r_sum == 28'd0)                w_res = 32'd0;
                else if (w_exp_n[9] || w_exp_n == 10'd0) w_res = 32'd0;
                else if (w_exp_n >= 10'd255)            w_res = {r_sign, 8'hFF, 23'd0};
                else                                    w_res = {r_sign, w_exp_n[7:0], w_frac};
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_spec     <= 1'b0;
                    r_spec_val <= '0;
                    r_sign     <= 1'b0;
                    r_sub      <= 1'b0;
                    r_exp      <= '0;
                    r_ml       <= '0;
                    r_ms       <= '0;
                    r_sum      <= '0;
                    r_res      <= '0;
                end else begin
                    if (w_align_en) begin
                        r_spec     <= w_spec;
                        r_spec_val <= w_spec_val;
                        r_sign     <= w_sl;
                        r_sub      <= w_a[31] ^ w_b[31];
                        r_exp      <= w_el;
                        r_ml       <= {w_ml, 3'b000};
                        r_ms       <= w_ms_al;
                    end
                    if (w_add_en)
                        r_sum <= r_sub ? ({1'b0, r_ml} - {1'b0, r_ms}) : ({1'b0, r_ml} + {1'b0, r_ms});
                    if (w_norm_en)
                        r_res <= w_res;
                end
            end

            assign result[32*gi +: 32] = r_res;
        end
    endgenerate
endmodule

// File: tb/tb_tf_adder.sv
// Directed bench for tf_adder (WIDTH=2): latency, rounding, special values,
// operand isolation while busy, and asynchronous reset abort.
module tb_tf_adder;
    localparam int WIDTH = 2;
    localparam int N = WIDTH * WIDTH;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            load = 1'b0;
    logic [N*32-1:0] A = '0;
    logic [N*32-1:0] B = '0;
    logic [N*32-1:0] result;
    logic            ready;
    int              total = 0;
    int              bad = 0;
    logic            rose;

    tf_adder #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .A      (A),
        .B      (B),
        .result (result),
        .ready  (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    function automatic logic [N*32-1:0] pack4(input logic [31:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic run_op(input string tag, input logic [N*32-1:0] a, input logic [N*32-1:0] b,
                          input logic [N*32-1:0] expv);
        int n;
        @(negedge clk);
        A = a; B = b; load = 1'b1;
        @(negedge clk);
        check({tag, "_busy"}, 32'(ready), 32'd0);
        A = ~a; B = ~b;
        n = 0;
        while (ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd3);
        for (int k = 0; k < N; k++)
            check($sformatf("%s_e%0d", tag, k), result[32*k +: 32], expv[32*k +: 32]);
        load = 1'b0;
        @(negedge clk);
        check({tag, "_idle_ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b0;
        #2;
        check("rst_ready", 32'(ready), 32'd0);
        for (int k = 0; k < N; k++)
            check($sformatf("rst_e%0d", k), result[32*k +: 32], 32'd0);

        @(negedge clk);
        reset = 1'b1;
        A = {N{32'h40BA_E148}};
        B = {N{32'h40BA_E148}};
        load = 1'b1;
        repeat (3) @(negedge clk);
        check("sum584_edge3_ready", 32'(ready), 32'd0);
        @(negedge clk);
        check("sum584_edge4_ready", 32'(ready), 32'd1);
        for (int k = 0; k < N; k++)
            check($sformatf("sum584_e%0d", k), result[32*k +: 32], 32'h413A_E148);
        repeat (2) @(negedge clk);
        check("sum584_hold_ready", 32'(ready), 32'd1);
        check("sum584_hold_e0", result[31:0], 32'h413A_E148);
        load = 1'b0;
        @(negedge clk);
        check("sum584_idle_ready", 32'(ready), 32'd1);

        run_op("mix",
               pack4(32'h3F80_0000, 32'h3F80_0000, 32'h3FC0_0000, 32'hC040_0000),
               pack4(32'h4000_0000, 32'hBF80_0000, 32'h3E80_0000, 32'h3F80_0000),
               pack4(32'h4040_0000, 32'h0000_0000, 32'h3FE0_0000, 32'hC000_0000));
        run_op("spec",
               pack4(32'h7F7F_FFFF, 32'h7FC0_0000, 32'h7F80_0000, 32'h3F80_0000),
               pack4(32'h7F7F_FFFF, 32'h3F80_0000, 32'hFF80_0000, 32'h3380_0000),
               pack4(32'h7F80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h3F80_0000));
        run_op("zero",
               pack4(32'h8000_0000, 32'h7F80_0000, 32'h0000_0001, 32'h3F80_0000),
               pack4(32'h8000_0000, 32'h3F80_0000, 32'h3F80_0000, 32'hBF80_0001),
               pack4(32'h8000_0000, 32'h7F80_0000, 32'h3F80_0000, 32'hB400_0000));
        run_op("edge",
               pack4(32'h0080_0001, 32'h3F7F_FFFF, 32'hFF80_0000, 32'h3F80_0000),
               pack4(32'h8080_0000, 32'h3300_0000, 32'h3F80_0000, 32'hFFC0_0001),
               pack4(32'h0000_0000, 32'h3F80_0000, 32'hFF80_0000, 32'h7FC0_0000));

        @(negedge clk);
        A = {N{32'h3F80_0000}};
        B = {N{32'h3F80_0000}};
        load = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd0);
        for (int k = 0; k < N; k++)
            check($sformatf("abort_e%0d", k), result[32*k +: 32], 32'd0);
        load = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        rose = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ready !== 1'b0) rose = 1'b1;
        end
        check("abort_no_ready", 32'(rose), 32'd0);

        run_op("post",
               pack4(32'h3F80_0000, 32'h3F80_0000, 32'h3FC0_0000, 32'hC040_0000),
               pack4(32'h4000_0000, 32'hBF80_0000, 32'h3E80_0000, 32'h3F80_0000),
               pack4(32'h4040_0000, 32'h0000_0000, 32'h3FE0_0000, 32'hC000_0000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tf_adder.md
TF_ADDER -- requirements
Module: tf_adder

Interface
REQ-001 Parameter WIDTH, default 2, SHALL set the matrix dimension; the block adds two WIDTH x WIDTH matrices of N = WIDTH*WIDTH elements.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit, SHALL be the reset, asynchronous and active-low.
REQ-004 Port load, input, 1 bit, SHALL be the start request, level-sensitive.
REQ-005 Port A, input, N*32 bits, SHALL carry operand matrix A; element k (row-major, k = row*WIDTH+col) occupies bits [32k+31:32k].
REQ-006 Port B, input, N*32 bits, SHALL carry operand matrix B, packed the same way as A.
REQ-007 Port result, output, N*32 bits, SHALL carry the sum matrix, packed the same way as A.
REQ-008 Port ready, output, 1 bit, SHALL indicate that result holds a completed sum.

Function
REQ-009 Each element SHALL be an IEEE-754 single-precision value: sign bit 31, exponent 30:23 (bias 127), fraction 22:0.
REQ-010 result[k] SHALL equal A[k] + B[k] for every k, with all N elements computed in parallel by N identical adder datapaths.
REQ-011 The control FSM SHALL have five states: IDLE, ALIGN, ADD, NORM, DONE.
REQ-012 In IDLE with load=1 at a rising edge, the block SHALL register all of A and B, clear ready and go to ALIGN; with load=0 it SHALL stay in IDLE.
REQ-013 ALIGN SHALL order the operands by magnitude and shift the smaller significand right by the exponent difference, keeping guard, round and sticky bits; a difference of 26 or more SHALL reduce the smaller operand to sticky only.
REQ-014 ADD SHALL add the significands on equal signs and subtract smaller from larger on opposite signs; the result SHALL take the sign of the larger-magnitude operand.
REQ-015 NORM SHALL:
- normalize with leading-one detection;
- round to nearest, ties to even;
- renormalize on mantissa overflow from rounding;
- register result;
- go to DONE.
REQ-016 In DONE, ready SHALL be 1 and result SHALL be held stable; the FSM SHALL stay in DONE while load=1 and return to IDLE when load=0.
REQ-017 ready SHALL remain 1 in IDLE after a completed operation until the next load is accepted.
REQ-018 Latency: load sampled high at edge N SHALL give ready=1 and a valid result after edge N+3.
REQ-019 Changes on A, B or load during ALIGN, ADD or NORM SHALL NOT affect the operation in progress.
REQ-020 Special cases, applied per element:
- subnormal inputs flush to signed zero;
- a subnormal or underflowed result flushes to +0;
- exponent overflow gives signed infinity;
- inf + inf of the same sign gives that infinity;
- inf + finite gives the infinity;
- inf + -inf, or any NaN input, gives 0x7FC00000.
REQ-021 Exact cancellation (x + -x) SHALL give +0 (0x00000000); 0 + 0 SHALL give +0 unless both inputs are -0, which gives -0.

Reset
REQ-022 With reset=0, and regardless of clk, the FSM SHALL go to IDLE, ready SHALL be 0, result SHALL be all zeros and the operand registers SHALL be cleared.
REQ-023 Reset asserted mid-operation SHALL abort it; after reset is released, the block SHALL wait for load with ready=0.

Verification
REQ-024 After reset, all A[k] = B[k] = 0x40BAE148 (5.84) with load held at 1 -> ready rises after the 4th rising edge; every result[k] = 0x413AE148 (11.68); ready stays 1 while load stays 1.
REQ-025 Mixed elements (1.0 + 2.0, 1.0 + -1.0, 1.5 + 0.25, -3.0 + 1.0) = (0x3F800000+0x40000000, 0x3F800000+0xBF800000, 0x3FC00000+0x3E800000, 0xC0400000+0x3F800000) -> results 0x40400000, 0x00000000, 0x3FE00000, 0xC0000000 respectively.
REQ-026 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000; 0x7FC00000 + 0x3F800000 -> 0x7FC00000; 0x7F800000 + 0xFF800000 -> 0x7FC00000; 0x3F800000 + 0x33800000 (tie) -> 0x3F800000.
REQ-027 Reset pulsed low during ADD -> ready=0 and result=0 immediately; no ready rise until a new load is accepted.
REQ-028 A and B changed on the edge after load is captured -> the result reflects the captured values; dropping load in DONE returns to IDLE, and raising it again starts a new sum with ready=0 until completion.
